blake2_msg_mgr: RTL and testbench

Next-generation BLAKE2 message/digest manager, parametrised for BLAKE2s (W=32) or BLAKE2b (W=64). It packs an input byte stream little-endian into 16-word message blocks. It holds each full block until it knows whether the block is the last one, then issues blocks to the compression core with the byte counter and final flag. It returns a truncated digest (DIGEST_BYTES) as a byte stream with ready/valid backpressure.

---
 rtl/blake2_pkg.sv | 28 ++
 rtl/blake2_msg_mgr_if.sv | 22 ++
 rtl/blake2_digest_ser.sv | 52 +++++
 rtl/blake2_msg_mgr.sv | 184 ++++++++++++++++++
 tb/tb_blake2_msg_mgr.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blake2_pkg.sv
// Shared types and sizing helpers for the BLAKE2 message/digest manager.
package blake2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      FULL,
      CMP,
      HWAIT,
      OUT
   } state_t;

   // Bytes per message block: 16 words of w bits.
   function automatic int block_bytes(input int w);
      return 2 * w;
   endfunction

   // Byte-counter width able to hold 0..block_bytes(w).
   function automatic int cnt_width(input int w);
      return $clog2(2 * w + 1);
   endfunction

   // Digest-counter width able to hold 0..nbytes.
   function automatic int ocnt_width(input int nbytes);
      return $clog2(nbytes + 1);
   endfunction

endpackage

// File: rtl/blake2_msg_mgr_if.sv
// Byte-stream interface of the BLAKE2 message manager: message bytes in,
// digest bytes out, both with valid/ready flow control.
interface blake2_msg_mgr_if;
   logic [7:0] data_in;
   logic       dv_in;
   logic       drdy_out;
   logic       finish;
   logic [7:0] data_out;
   logic       dv_out;
   logic       dout_rdy;
   logic       data_end;

   modport master (
      output data_in, dv_in, finish, dout_rdy,
      input  drdy_out, data_out, dv_out, data_end
   );

   modport slave (
      input  data_in, dv_in, finish, dout_rdy,
      output drdy_out, data_out, dv_out, data_end
   );
endinterface

// File: rtl/blake2_digest_ser.sv
// Digest serializer: loads the chaining value and streams its low
// DIGEST_BYTES bytes out, byte 0 first, under valid/ready backpressure.
module blake2_digest_ser
   import blake2_pkg::*;
#(
   parameter int W            = 32,
   parameter int DIGEST_BYTES = W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_clr,
   input  logic           i_load,
   input  logic [8*W-1:0] i_h,
   input  logic           i_rdy,
   output logic [7:0]     o_data,
   output logic           o_valid,
   output logic           o_end,
   output logic           o_done
);

   localparam int            OW        = ocnt_width(DIGEST_BYTES);
   localparam logic [OW-1:0] OCNT_LOAD = OW'(DIGEST_BYTES);
   localparam logic [OW-1:0] OCNT_ONE  = OW'(1);

   logic [8*W-1:0] r_h;
   logic [OW-1:0]  r_ocnt;
   logic           w_fire;

   assign o_valid = (r_ocnt != '0);
   assign w_fire  = o_valid & i_rdy;
   assign o_data  = r_h[7:0];
   assign o_end   = (r_ocnt == OCNT_ONE);
   assign o_done  = w_fire & o_end;

   // Digest register: load on request, shift one byte per accepted handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h    <= '0;
         r_ocnt <= '0;
      end else if (i_clr) begin
         r_h    <= '0;
         r_ocnt <= '0;
      end else if (i_load) begin
         r_h    <= i_h;
         r_ocnt <= OCNT_LOAD;
      end else if (w_fire) begin
         r_h    <= {8'h00, r_h[8*W-1:8]};
         r_ocnt <= r_ocnt - OCNT_ONE;
      end
   end

endmodule

// File: rtl/blake2_msg_mgr.sv
// BLAKE2 message/digest manager: packs message bytes little-endian into
// 16-word blocks, holds a full block until it is known whether it is the
// last one, issues blocks with byte count and final flag, then streams a
// truncated digest. Optional macro BLAKE2_OUT_MASK_EN XORs OUT_MASK into
// the digest when it is loaded.
module blake2_msg_mgr
   import blake2_pkg::*;
#(
   parameter int             W            = 32,
   parameter int             DIGEST_BYTES = W,
   parameter logic [8*W-1:0] OUT_MASK     = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   blake2_msg_mgr_if.slave   bus,
   output logic              msg_strobe,
   output logic [16*W-1:0]   m_out,
   output logic [2*W-1:0]    t_out,
   output logic              f_out,
   input  logic              cmp_done,
   input  logic [8*W-1:0]    h_in,
   input  logic              h_rdy,
   output logic              busy
);

   localparam int             BB       = block_bytes(W);
   localparam int             CW       = cnt_width(W);
   localparam logic [CW-1:0]  CNT_LAST = CW'(BB - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [2*W-1:0] T_ONE    = (2*W)'(1);

   state_t          r_state, w_state_nxt;
   logic [16*W-1:0] r_m;
   logic [2*W-1:0]  r_t, r_tout;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_pend;
   logic            r_fin_pend, r_strobe, r_f;
   logic            w_write, w_issue, w_final, w_refill, w_load, w_done;
   logic [CW+2:0]   w_boff;
   logic [8*W-1:0]  w_h_load;

`ifdef BLAKE2_OUT_MASK_EN
   assign w_h_load = h_in ^ OUT_MASK;
`else
   assign w_h_load = h_in;
`endif

   assign w_boff       = {r_cnt, 3'b000};
   assign bus.drdy_out = (r_state == FILL) || (r_state == FULL);
   assign busy         = (r_state != IDLE);
   assign msg_strobe   = r_strobe;
   assign m_out        = r_m;
   assign t_out        = r_tout;
   assign f_out        = r_f;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and datapath controls; a pending finish outranks new bytes.
   always_comb begin
      w_state_nxt = r_state;
      w_write     = 1'b0;
      w_issue     = 1'b0;
      w_final     = 1'b0;
      w_refill    = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         IDLE: ;
         FILL: begin
            if (r_fin_pend || (bus.finish && !bus.dv_in)) begin
               w_final     = 1'b1;
               w_state_nxt = HWAIT;
            end else if (bus.dv_in) begin
               w_write = 1'b1;
               if (r_cnt == CNT_LAST) w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (r_fin_pend || (bus.finish && !bus.dv_in)) begin
               w_final     = 1'b1;
               w_state_nxt = HWAIT;
            end else if (bus.dv_in) begin
               w_issue     = 1'b1;
               w_state_nxt = CMP;
            end
         end
         CMP: begin
            if (cmp_done) begin
               w_refill    = 1'b1;
               w_state_nxt = FILL;
            end
         end
         HWAIT: begin
            if (h_rdy) begin
               w_load      = 1'b1;
               w_state_nxt = OUT;
            end
         end
         OUT: begin
            if (w_done) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (start) begin
         w_write     = 1'b0;
         w_issue     = 1'b0;
         w_final     = 1'b0;
         w_refill    = 1'b0;
         w_load      = 1'b0;
         w_state_nxt = FILL;
      end
   end

   // Block buffer, byte counters, pending byte and strobe registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m        <= '0;
         r_t        <= '0;
         r_tout     <= '0;
         r_cnt      <= '0;
         r_pend     <= '0;
         r_fin_pend <= 1'b0;
         r_strobe   <= 1'b0;
         r_f        <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         if (start) begin
            r_m        <= '0;
            r_t        <= '0;
            r_tout     <= '0;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_fin_pend <= 1'b0;
            r_f        <= 1'b0;
         end else begin
            if (w_write) begin
               r_m[w_boff +: 8] <= bus.data_in;
               r_cnt            <= r_cnt + CNT_ONE;
               r_t              <= r_t + T_ONE;
            end
            // The held block is issued with the count before the new byte.
            if (w_issue) begin
               r_pend   <= bus.data_in;
               r_t      <= r_t + T_ONE;
               r_tout   <= r_t;
               r_f      <= 1'b0;
               r_strobe <= 1'b1;
            end
            if (w_final) begin
               r_tout     <= r_t;
               r_f        <= 1'b1;
               r_strobe   <= 1'b1;
               r_fin_pend <= 1'b0;
            end
            if ((w_write || w_issue) && bus.finish) r_fin_pend <= 1'b1;
            if (w_refill) begin
               r_m   <= {{(16*W-8){1'b0}}, r_pend};
               r_cnt <= CNT_ONE;
            end
         end
      end
   end

   blake2_digest_ser #(
      .W            (W),
      .DIGEST_BYTES (DIGEST_BYTES)
   ) u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (start),
      .i_load  (w_load),
      .i_h     (w_h_load),
      .i_rdy   (bus.dout_rdy),
      .o_data  (bus.data_out),
      .o_valid (bus.dv_out),
      .o_end   (bus.data_end),
      .o_done  (w_done)
   );

endmodule

// File: tb/tb_blake2_msg_mgr.sv
// Directed testbench for blake2_msg_mgr: a BLAKE2s instance (W=32) for
// message packing and a BLAKE2b instance (W=64, 32-byte digest) for digest
// streaming and abort.
module tb_blake2_msg_mgr;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          start32, cmp32, hrdy32, strobe32, f32, busy32;
   logic [255:0]  h32;
   logic [511:0]  m32;
   logic [63:0]   t32;
   logic          start64, cmp64, hrdy64, strobe64, f64, busy64;
   logic [511:0]  h64;
   logic [1023:0] m64;
   logic [127:0]  t64;

   blake2_msg_mgr_if b32();
   blake2_msg_mgr_if b64();

   blake2_msg_mgr #(.W(32)) u32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .bus(b32),
      .msg_strobe(strobe32), .m_out(m32), .t_out(t32), .f_out(f32),
      .cmp_done(cmp32), .h_in(h32), .h_rdy(hrdy32), .busy(busy32)
   );

   blake2_msg_mgr #(.W(64), .DIGEST_BYTES(32)) u64 (
      .clk(clk), .rst_n(rst_n), .start(start64), .bus(b64),
      .msg_strobe(strobe64), .m_out(m64), .t_out(t64), .f_out(f64),
      .cmp_done(cmp64), .h_in(h64), .h_rdy(hrdy64), .busy(busy64)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [511:0]  q_m32[$];
   logic [63:0]   q_t32[$];
   logic          q_f32[$];
   logic [1023:0] q_m64[$];
   logic [127:0]  q_t64[$];
   logic          q_f64[$];

   // Record every block strobe, sampled on the falling edge.
   always @(negedge clk) begin
      if (strobe32 === 1'b1) begin
         q_m32.push_back(m32); q_t32.push_back(t32); q_f32.push_back(f32);
      end
      if (strobe64 === 1'b1) begin
         q_m64.push_back(m64); q_t64.push_back(t64); q_f64.push_back(f64);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_m32.delete(); q_t32.delete(); q_f32.delete();
      q_m64.delete(); q_t64.delete(); q_f64.delete();
   endtask

   task automatic test_reset();
      #3;
      n_vec++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL reset_busy32: got %b want 0", busy32); end
      n_vec++; if (b32.drdy_out !== 1'b0) begin n_err++; $display("FAIL reset_drdy32: got %b want 0", b32.drdy_out); end
      n_vec++; if (strobe32 !== 1'b0 || f32 !== 1'b0) begin n_err++; $display("FAIL reset_strobe_f32: got %b%b want 00", strobe32, f32); end
      n_vec++; if (m32 !== 512'd0 || t32 !== 64'd0) begin n_err++; $display("FAIL reset_m_t32: got t=%h want 0", t32); end
      n_vec++; if (b32.dv_out !== 1'b0 || b32.data_end !== 1'b0 || b32.data_out !== 8'h00) begin n_err++; $display("FAIL reset_out32: got dv=%b end=%b d=%h want 0", b32.dv_out, b32.data_end, b32.data_out); end
      n_vec++; if (busy64 !== 1'b0 || b64.dv_out !== 1'b0 || m64 !== 1024'd0 || t64 !== 128'd0) begin n_err++; $display("FAIL reset_64: got busy=%b dv=%b want 0", busy64, b64.dv_out); end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      n_vec++; if (busy32 !== 1'b0 || b32.drdy_out !== 1'b0) begin n_err++; $display("FAIL post_reset_idle32: got busy=%b drdy=%b want 00", busy32, b32.drdy_out); end
   endtask

   task automatic test_idle_ignore();
      clear_q();
      b32.data_in = 8'h55; b32.dv_in = 1'b1; b32.finish = 1'b1;
      repeat (2) tick();
      b32.dv_in = 1'b0; b32.finish = 1'b0;
      repeat (2) tick();
      n_vec++; if (q_m32.size() !== 0 || busy32 !== 1'b0) begin n_err++; $display("FAIL idle_ignore: got strobes=%0d busy=%b want 0 0", q_m32.size(), busy32); end
   endtask

   task automatic test_short_msg();
      logic [7:0] bytes [3];
      bytes[0] = 8'h61; bytes[1] = 8'h62; bytes[2] = 8'h63;
      clear_q();
      start32 = 1'b1; tick(); start32 = 1'b0;
      n_vec++; if (b32.drdy_out !== 1'b1 || busy32 !== 1'b1) begin n_err++; $display("FAIL start_fill32: got drdy=%b busy=%b want 11", b32.drdy_out, busy32); end
      for (int i = 0; i < 3; i++) begin
         b32.data_in = bytes[i]; b32.dv_in = 1'b1; tick();
      end
      b32.dv_in = 1'b0;
      // finish held for three cycles must still give a single strobe
      b32.finish = 1'b1; repeat (3) tick(); b32.finish = 1'b0;
      tick();
      n_vec++; if (q_m32.size() !== 1) begin n_err++; $display("FAIL short_count: got %0d want 1", q_m32.size()); end
      if (q_m32.size() > 0) begin
         n_vec++; if (q_m32[0] !== 512'h636261) begin n_err++; $display("FAIL short_m: got %h want 636261", q_m32[0]); end
         n_vec++; if (q_t32[0] !== 64'd3) begin n_err++; $display("FAIL short_t: got %0d want 3", q_t32[0]); end
         n_vec++; if (q_f32[0] !== 1'b1) begin n_err++; $display("FAIL short_f: got %b want 1", q_f32[0]); end
      end
   endtask

   task automatic test_empty();
      clear_q();
      start32 = 1'b1; tick(); start32 = 1'b0;
      b32.finish = 1'b1; tick(); b32.finish = 1'b0;
      tick();
      n_vec++; if (q_m32.size() !== 1) begin n_err++; $display("FAIL empty_count: got %0d want 1", q_m32.size()); end
      if (q_m32.size() > 0) begin
         n_vec++; if (q_m32[0] !== 512'd0 || q_t32[0] !== 64'd0 || q_f32[0] !== 1'b1) begin n_err++; $display("FAIL empty_block: got t=%0d f=%b m=%h want t=0 f=1 m=0", q_t32[0], q_f32[0], q_m32[0]); end
      end
   endtask

   task automatic test_full_block();
      logic [511:0] exp_m;
      clear_q();
      exp_m = '0;
      start32 = 1'b1; tick(); start32 = 1'b0;
      for (int i = 0; i < 64; i++) begin
         b32.data_in = 8'(i); b32.dv_in = 1'b1; tick();
         exp_m[8*i +: 8] = 8'(i);
      end
      b32.dv_in = 1'b0;
      repeat (3) tick();
      n_vec++; if (q_m32.size() !== 0) begin n_err++; $display("FAIL full_early_strobe: got %0d want 0", q_m32.size()); end
      n_vec++; if (b32.drdy_out !== 1'b1) begin n_err++; $display("FAIL full_drdy: got %b want 1", b32.drdy_out); end
      b32.finish = 1'b1; tick(); b32.finish = 1'b0;
      tick();
      n_vec++; if (q_m32.size() !== 1) begin n_err++; $display("FAIL full_count: got %0d want 1", q_m32.size()); end
      if (q_m32.size() > 0) begin
         n_vec++; if (q_t32[0] !== 64'd64 || q_f32[0] !== 1'b1) begin n_err++; $display("FAIL full_tf: got t=%0d f=%b want t=64 f=1", q_t32[0], q_f32[0]); end
         n_vec++; if (q_m32[0] !== exp_m) begin n_err++; $display("FAIL full_m: got %h want %h", q_m32[0], exp_m); end
      end
   endtask

   task automatic test_two_blocks();
      logic [511:0] exp_m, exp_m2;
      int waited;
      clear_q();
      exp_m = '0; exp_m2 = '0; exp_m2[7:0] = 8'h50;
      start32 = 1'b1; tick(); start32 = 1'b0;
      for (int i = 0; i < 65; i++) begin
         b32.data_in = 8'(i + 16); b32.dv_in = 1'b1;
         b32.finish = (i == 64);
         if (i < 64) exp_m[8*i +: 8] = 8'(i + 16);
         tick();
      end
      b32.dv_in = 1'b0; b32.finish = 1'b0;
      n_vec++; if (b32.drdy_out !== 1'b0) begin n_err++; $display("FAIL cmp_drdy: got %b want 0", b32.drdy_out); end
      repeat (5) tick();
      n_vec++; if (m32 !== exp_m || t32 !== 64'd64 || f32 !== 1'b0) begin n_err++; $display("FAIL cmp_hold: got t=%0d f=%b want t=64 f=0", t32, f32); end
      cmp32 = 1'b1; tick(); cmp32 = 1'b0;
      waited = 0;
      while (q_m32.size() < 2 && waited < 20) begin tick(); waited++; end
      n_vec++; if (q_m32.size() !== 2) begin n_err++; $display("FAIL two_count: got %0d want 2", q_m32.size()); end
      if (q_m32.size() >= 2) begin
         n_vec++; if (q_t32[0] !== 64'd64 || q_f32[0] !== 1'b0) begin n_err++; $display("FAIL two_first_tf: got t=%0d f=%b want t=64 f=0", q_t32[0], q_f32[0]); end
         n_vec++; if (q_m32[0] !== exp_m) begin n_err++; $display("FAIL two_first_m: got %h want %h", q_m32[0], exp_m); end
         n_vec++; if (q_t32[1] !== 64'd65 || q_f32[1] !== 1'b1) begin n_err++; $display("FAIL two_second_tf: got t=%0d f=%b want t=65 f=1", q_t32[1], q_f32[1]); end
         n_vec++; if (q_m32[1] !== exp_m2) begin n_err++; $display("FAIL two_second_m: got %h want %h", q_m32[1], exp_m2); end
      end
   endtask

   task automatic test_digest();
      int got;
      start64 = 1'b1; tick(); start64 = 1'b0;
      b64.finish = 1'b1; tick(); b64.finish = 1'b0;
      tick();
      for (int k = 0; k < 64; k++) h64[8*k +: 8] = 8'(k);
      hrdy64 = 1'b1; tick(); hrdy64 = 1'b0;
      n_vec++; if (b64.dv_out !== 1'b1 || b64.data_out !== 8'h00) begin n_err++; $display("FAIL dig_first: got dv=%b d=%h want dv=1 d=00", b64.dv_out, b64.data_out); end
      got = 0;
      for (int c = 0; c < 200 && got < 32; c++) begin
         b64.dout_rdy = (c % 2 == 0);
         @(negedge clk);
         if (b64.dv_out === 1'b1 && b64.dout_rdy === 1'b1) begin
            n_vec++; if (b64.data_out !== 8'(got)) begin n_err++; $display("FAIL dig_byte%0d: got %h want %h", got, b64.data_out, 8'(got)); end
            n_vec++; if (b64.data_end !== (got == 31)) begin n_err++; $display("FAIL dig_end%0d: got %b want %b", got, b64.data_end, (got == 31)); end
            got++;
         end else if (b64.dv_out !== 1'b1) begin
            c = 200;
         end
         @(posedge clk); #1;
      end
      b64.dout_rdy = 1'b0;
      tick();
      n_vec++; if (got !== 32) begin n_err++; $display("FAIL dig_count: got %0d want 32", got); end
      n_vec++; if (b64.dv_out !== 1'b0 || busy64 !== 1'b0) begin n_err++; $display("FAIL dig_idle: got dv=%b busy=%b want 00", b64.dv_out, busy64); end
   endtask

   task automatic test_abort();
      logic [1023:0] exp_m;
      exp_m = '0; exp_m[7:0] = 8'hAB;
      start64 = 1'b1; tick(); start64 = 1'b0;
      b64.finish = 1'b1; tick(); b64.finish = 1'b0;
      tick();
      hrdy64 = 1'b1; tick(); hrdy64 = 1'b0;
      b64.dout_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (b64.dv_out !== 1'b1 || b64.data_out !== 8'(k)) begin n_err++; $display("FAIL abort_pre%0d: got dv=%b d=%h want dv=1 d=%h", k, b64.dv_out, b64.data_out, 8'(k)); end
         @(posedge clk); #1;
      end
      b64.dout_rdy = 1'b0;
      start64 = 1'b1; tick(); start64 = 1'b0;
      n_vec++; if (b64.dv_out !== 1'b0) begin n_err++; $display("FAIL abort_dv: got %b want 0", b64.dv_out); end
      n_vec++; if (busy64 !== 1'b1 || b64.drdy_out !== 1'b1) begin n_err++; $display("FAIL abort_fill: got busy=%b drdy=%b want 11", busy64, b64.drdy_out); end
      clear_q();
      b64.data_in = 8'hAB; b64.dv_in = 1'b1; b64.finish = 1'b1; tick();
      b64.dv_in = 1'b0; b64.finish = 1'b0;
      repeat (2) tick();
      n_vec++; if (q_m64.size() !== 1) begin n_err++; $display("FAIL abort_count: got %0d want 1", q_m64.size()); end
      if (q_m64.size() > 0) begin
         n_vec++; if (q_t64[0] !== 128'd1 || q_f64[0] !== 1'b1) begin n_err++; $display("FAIL abort_tf: got t=%0d f=%b want t=1 f=1", q_t64[0], q_f64[0]); end
         n_vec++; if (q_m64[0] !== exp_m) begin n_err++; $display("FAIL abort_m: got %h want %h", q_m64[0], exp_m); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start32 = 1'b0; cmp32 = 1'b0; hrdy32 = 1'b0; h32 = '0;
      start64 = 1'b0; cmp64 = 1'b0; hrdy64 = 1'b0; h64 = '0;
      b32.data_in = '0; b32.dv_in = 1'b0; b32.finish = 1'b0; b32.dout_rdy = 1'b0;
      b64.data_in = '0; b64.dv_in = 1'b0; b64.finish = 1'b0; b64.dout_rdy = 1'b0;
      test_reset();
      test_idle_ignore();
      test_short_msg();
      test_empty();
      test_full_block();
      test_two_blocks();
      test_digest();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
